conv_frame_src: RTL and testbench

CONV_FRAME_SRC -- requirements
Module: conv_frame_src

---
 rtl/conv_pkg.sv | 23 ++
 rtl/stream_src_chan.sv | 95 +++++++++
 rtl/conv_frame_src.sv | 118 +++++++++++
 tb/tb_conv_frame_src.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared sizes, FSM state type and stall-LFSR constants for the convolution frame source.
package conv_pkg;

    localparam int DATA_WIDTH_X = 8;
    localparam int DATA_WIDTH_F = 8;
    localparam int X_SIZE       = 128;
    localparam int F_SIZE       = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_SEED_X = 8'hA5;
    localparam logic [7:0] LFSR_SEED_F = 8'h3C;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/stream_src_chan.sv
// One valid/ready source channel: frame buffer, element counter, output registers.
// With CONV_SRC_STALL_EN defined, an LFSR gates each new assertion of valid.
module stream_src_chan
    import conv_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter int         SIZE   = 128,
    parameter int         ADDR_W = 7,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_start,
`ifdef CONV_SRC_STALL_EN
    input  logic              i_busy,
`endif
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_finished
);

    localparam int IDX_W = $clog2(SIZE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

    logic [DATA_W-1:0] r_mem [SIZE];
    logic [IDX_W-1:0]  r_count;
    logic              r_active;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_xfer;
    logic              w_gate;
    logic [IDX_W-1:0]  w_nextIdx;

    assign w_xfer    = r_valid & i_ready;
    assign w_nextIdx = r_count + 1'b1;

`ifdef CONV_SRC_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (i_busy) begin
            r_lfsr <= lfsrStep(r_lfsr);
        end
    end

    assign w_gate = r_lfsr[0];
`else
    assign w_gate = 1'b1;
`endif

    // Buffer holds its contents across reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (i_wr_en && (32'(i_wr_addr) < 32'(SIZE))) begin
            r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else if (i_start) begin
            r_count  <= '0;
            r_active <= 1'b1;
            r_valid  <= w_gate;
            r_data   <= r_mem[IDX_W'(0)];
        end else if (r_active) begin
            if (w_xfer && (r_count == LAST)) begin
                r_active <= 1'b0;
                r_valid  <= 1'b0;
            end else if (w_xfer) begin
                r_count <= w_nextIdx;
                r_valid <= w_gate;
                r_data  <= r_mem[w_nextIdx];
            end else if (!r_valid) begin
                // Element pending but not yet presented (stall gate was low).
                r_valid <= w_gate;
                r_data  <= r_mem[r_count];
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_finished = ~r_active;

endmodule

// File: rtl/conv_frame_src.sv
// Frame source feeding one X frame and one F frame to the convolution engine.
// Optional stall insertion: define CONV_SRC_STALL_EN.
module conv_frame_src
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH_X = conv_pkg::DATA_WIDTH_X,
    parameter int DATA_WIDTH_F = conv_pkg::DATA_WIDTH_F,
    parameter int X_SIZE       = conv_pkg::X_SIZE,
    parameter int F_SIZE       = conv_pkg::F_SIZE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ld_wr_en,
    input  logic                           ld_sel,
    input  logic [$clog2(X_SIZE)-1:0]      ld_addr,
    input  logic [((DATA_WIDTH_X > DATA_WIDTH_F) ? DATA_WIDTH_X : DATA_WIDTH_F)-1:0] ld_data,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           m_valid_x,
    input  logic                           m_ready_x,
    output logic signed [DATA_WIDTH_X-1:0] m_data_out_x,
    output logic                           m_valid_f,
    input  logic                           m_ready_f,
    output logic signed [DATA_WIDTH_F-1:0] m_data_out_f
);

    localparam int ADDR_W = $clog2(X_SIZE);

    state_t r_state;
    state_t w_nextState;
    logic   w_startFrame;
    logic   w_finX;
    logic   w_finF;
    logic   w_wrX;
    logic   w_wrF;

    assign w_startFrame = (r_state == IDLE) && start;
    assign w_wrX        = ld_wr_en && !busy && !ld_sel;
    assign w_wrF        = ld_wr_en && !busy && ld_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // SEND waits for both channels, whichever finishes last.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (w_finX && w_finF) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    stream_src_chan #(
        .DATA_W (DATA_WIDTH_X),
        .SIZE   (X_SIZE),
        .ADDR_W (ADDR_W),
        .SEED   (LFSR_SEED_X)
    ) u_chanX (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wrX),
        .i_wr_addr  (ld_addr),
        .i_wr_data  (ld_data[DATA_WIDTH_X-1:0]),
        .i_start    (w_startFrame),
`ifdef CONV_SRC_STALL_EN
        .i_busy     (busy),
`endif
        .i_ready    (m_ready_x),
        .o_valid    (m_valid_x),
        .o_data     (m_data_out_x),
        .o_finished (w_finX)
    );

    stream_src_chan #(
        .DATA_W (DATA_WIDTH_F),
        .SIZE   (F_SIZE),
        .ADDR_W (ADDR_W),
        .SEED   (LFSR_SEED_F)
    ) u_chanF (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wrF),
        .i_wr_addr  (ld_addr),
        .i_wr_data  (ld_data[DATA_WIDTH_F-1:0]),
        .i_start    (w_startFrame),
`ifdef CONV_SRC_STALL_EN
        .i_busy     (busy),
`endif
        .i_ready    (m_ready_f),
        .o_valid    (m_valid_f),
        .o_data     (m_data_out_f),
        .o_finished (w_finF)
    );

endmodule

// File: tb/tb_conv_frame_src.sv
// Directed scoreboard bench for conv_frame_src; exact-cycle checks apply when
// CONV_SRC_STALL_EN is undefined, ordering/hold checks apply in both builds.
module tb_conv_frame_src;

    logic       clk;
    logic       reset;
    logic       ld_wr_en;
    logic       ld_sel;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       m_valid_x;
    logic       m_ready_x;
    logic [7:0] m_data_out_x;
    logic       m_valid_f;
    logic       m_ready_f;
    logic [7:0] m_data_out_f;

    int vectors     = 0;
    int miscompares = 0;
    int doneCount   = 0;

    logic [7:0] xModel [128];
    logic [7:0] fModel [32];
    logic [7:0] qX [$];
    logic [7:0] qF [$];

    logic       prevHoldX = 1'b0;
    logic       prevHoldF = 1'b0;
    logic [7:0] prevDataX = '0;
    logic [7:0] prevDataF = '0;

    conv_frame_src dut (
        .clk          (clk),
        .reset        (reset),
        .ld_wr_en     (ld_wr_en),
        .ld_sel       (ld_sel),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .m_data_out_x (m_data_out_x),
        .m_valid_f    (m_valid_f),
        .m_ready_f    (m_ready_f),
        .m_data_out_f (m_data_out_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input int addr, input logic [7:0] data);
        ld_wr_en = 1'b1;
        ld_sel   = sel;
        ld_addr  = 7'(addr);
        ld_data  = data;
        @(posedge clk);
        #1;
        ld_wr_en = 1'b0;
    endtask

    task automatic pushFrame();
        for (int i = 0; i < 128; i++) qX.push_back(xModel[i]);
        for (int i = 0; i < 32; i++) qF.push_back(fModel[i]);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
    endtask

    task automatic waitX(input logic [7:0] value, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_valid_x && m_data_out_x == value) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_x_elem", 32'(m_data_out_x), 32'(value));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},    32'(busy),         32'd0);
        checkOutput({tag, "_done"},    32'(done),         32'd0);
        checkOutput({tag, "_valid_x"}, 32'(m_valid_x),    32'd0);
        checkOutput({tag, "_valid_f"}, 32'(m_valid_f),    32'd0);
        checkOutput({tag, "_data_x"},  32'(m_data_out_x), 32'd0);
        checkOutput({tag, "_data_f"},  32'(m_data_out_f), 32'd0);
    endtask

    // Scoreboard monitor: pops an expected element on every transfer and
    // checks that a stalled element keeps valid and data steady.
    always @(negedge clk) begin
        if (!reset) begin
            prevHoldX = 1'b0;
            prevHoldF = 1'b0;
        end else begin
            if (prevHoldX) begin
                checkOutput("x_hold_valid", 32'(m_valid_x), 32'd1);
                checkOutput("x_hold_data", 32'(m_data_out_x), 32'(prevDataX));
            end
            if (prevHoldF) begin
                checkOutput("f_hold_valid", 32'(m_valid_f), 32'd1);
                checkOutput("f_hold_data", 32'(m_data_out_f), 32'(prevDataF));
            end
            if (m_valid_x && m_ready_x) begin
                if (qX.size() == 0) checkOutput("x_extra_xfer", 32'(qX.size()), 32'd1);
                else checkOutput("x_data", 32'(m_data_out_x), 32'(qX.pop_front()));
            end
            if (m_valid_f && m_ready_f) begin
                if (qF.size() == 0) checkOutput("f_extra_xfer", 32'(qF.size()), 32'd1);
                else checkOutput("f_data", 32'(m_data_out_f), 32'(qF.pop_front()));
            end
            prevHoldX = m_valid_x && !m_ready_x;
            prevHoldF = m_valid_f && !m_ready_f;
            prevDataX = m_data_out_x;
            prevDataF = m_data_out_f;
        end
        if (done) doneCount++;
    end

    initial begin
        int n;
        int doneBefore;

        reset     = 1'b0;
        ld_wr_en  = 1'b0;
        ld_sel    = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        start     = 1'b0;
        m_ready_x = 1'b0;
        m_ready_f = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load X[i]=i, F[i]=-i; an F write past F_SIZE must not alias.
        for (int i = 0; i < 128; i++) begin
            xModel[i] = 8'(i);
            applyStimulus(1'b0, i, xModel[i]);
        end
        for (int i = 0; i < 32; i++) begin
            fModel[i] = 8'(-i);
            applyStimulus(1'b1, i, fModel[i]);
        end
        applyStimulus(1'b1, 40, 8'h77);

        // Frame 1: both ready throughout.
        $display("[TB] frame 1: full-rate transfer");
        m_ready_x = 1'b1;
        m_ready_f = 1'b1;
        pushFrame();
        pulseStart();
`ifndef CONV_SRC_STALL_EN
        @(negedge clk);
        checkOutput("first_valid_x", 32'(m_valid_x), 32'd1);
        checkOutput("first_data_x", 32'(m_data_out_x), 32'd0);
        checkOutput("first_valid_f", 32'(m_valid_f), 32'd1);
        checkOutput("first_data_f", 32'(m_data_out_f), 32'd0);
        checkOutput("first_busy", 32'(busy), 32'd1);
        waitDone(400, n);
        checkOutput("done_latency_f1", 32'(n), 32'd129);
`else
        waitDone(4000, n);
`endif
        checkOutput("f1_busy_at_done", 32'(busy), 32'd1);
        checkOutput("f1_qx_empty", 32'(qX.size()), 32'd0);
        checkOutput("f1_qf_empty", 32'(qF.size()), 32'd0);

        // Frame 2: start during DONE is ignored, start the cycle after begins a frame.
        $display("[TB] frame 2: back-to-back start and X stall at element 40");
        pushFrame();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("f1_busy_after_done", 32'(busy), 32'd0);
        checkOutput("f1_done_after", 32'(done), 32'd0);
        checkOutput("f1_valid_x_after", 32'(m_valid_x), 32'd0);
        checkOutput("f1_done_count", 32'(doneCount), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("f2_busy", 32'(busy), 32'd1);
`ifndef CONV_SRC_STALL_EN
        checkOutput("f2_first_valid", 32'(m_valid_x), 32'd1);
        checkOutput("f2_first_data", 32'(m_data_out_x), 32'd0);
        waitX(8'd39, 300);
        @(posedge clk);
        #1;
        m_ready_x = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall40_valid", 32'(m_valid_x), 32'd1);
            checkOutput("stall40_data", 32'(m_data_out_x), 32'd40);
        end
        @(posedge clk);
        #1;
        m_ready_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("resume41_data", 32'(m_data_out_x), 32'd41);
`endif
        waitDone(4000, n);
        checkOutput("f2_qx_empty", 32'(qX.size()), 32'd0);
        checkOutput("f2_qf_empty", 32'(qF.size()), 32'd0);

        // Frame 3: F starved for 200 cycles; restart and loads while busy are ignored.
        $display("[TB] frame 3: F starved, ignored start and loads");
        @(posedge clk);
        #1;
        m_ready_f = 1'b0;
        pushFrame();
        pulseStart();
        pulseStart();
        applyStimulus(1'b0, 5, 8'hEE);
        applyStimulus(1'b1, 3, 8'h55);
`ifndef CONV_SRC_STALL_EN
        repeat (200) @(posedge clk);
`else
        repeat (700) @(posedge clk);
`endif
        @(negedge clk);
        checkOutput("f3_x_complete", 32'(qX.size()), 32'd0);
        checkOutput("f3_busy_held", 32'(busy), 32'd1);
        checkOutput("f3_no_early_done", 32'(doneCount), 32'd2);
        checkOutput("f3_f_untouched", 32'(qF.size()), 32'd32);
`ifndef CONV_SRC_STALL_EN
        checkOutput("f3_valid_f_held", 32'(m_valid_f), 32'd1);
        checkOutput("f3_data_f_held", 32'(m_data_out_f), 32'd0);
`endif
        @(posedge clk);
        #1;
        m_ready_f = 1'b1;
`ifndef CONV_SRC_STALL_EN
        waitDone(100, n);
        checkOutput("done_latency_f3", 32'(n), 32'd34);
`else
        waitDone(2000, n);
`endif
        checkOutput("f3_qf_empty_at_done", 32'(qF.size()), 32'd0);

        // Frame 4: buffers unchanged by busy loads; reset aborts at X element 70.
        $display("[TB] frame 4: reset abort mid-frame");
        @(posedge clk);
        #1;
        pushFrame();
        pulseStart();
        waitX(8'd70, 2000);
        #1;
        reset = 1'b0;
        #1;
        checkAllZero("abort");
        qX.delete();
        qF.delete();
        doneBefore = doneCount;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount), 32'(doneBefore));
        checkOutput("abort_idle", 32'(busy), 32'd0);
        checkOutput("abort_valid_x", 32'(m_valid_x), 32'd0);

        // Frame 5: new frame after abort starts at element 0.
        $display("[TB] frame 5: restart after reset");
        @(posedge clk);
        #1;
        pushFrame();
        pulseStart();
`ifndef CONV_SRC_STALL_EN
        @(negedge clk);
        checkOutput("f5_first_valid", 32'(m_valid_x), 32'd1);
        checkOutput("f5_first_data", 32'(m_data_out_x), 32'd0);
`endif
        waitDone(4000, n);
        checkOutput("f5_qx_empty", 32'(qX.size()), 32'd0);
        checkOutput("f5_qf_empty", 32'(qF.size()), 32'd0);
        @(negedge clk);
        checkOutput("total_done_pulses", 32'(doneCount), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
